// File: rtl/capture_if.sv
// Signal bundle between the capture controller and its neighbours (command decoder, sampler,
// sample memory, readout). The controller uses the slave modport; the environment uses master.
interface capture_if #(
    parameter int unsigned CHLS  = 32,
    parameter int unsigned CNT_W = 16
);
    logic             cmd_vld_i;
    logic [7:0]       cmd_op_i;
    logic [31:0]      cmd_arg_i;
    logic [23:0]      fdiv_o;
    logic             set_div_o;
    logic [CHLS-1:0]  smpls_i;
    logic             stb_i;
    logic             trg_i;
    logic             we_o;
    logic [CHLS-1:0]  wdata_o;
    logic             rd_start_o;
    logic [CNT_W-1:0] rd_len_o;
    logic             rd_done_i;
    logic [1:0]       state_o;
    logic             err_o;

    modport master (
        output cmd_vld_i, cmd_op_i, cmd_arg_i, smpls_i, stb_i, trg_i, rd_done_i,
        input  fdiv_o, set_div_o, we_o, wdata_o, rd_start_o, rd_len_o, state_o, err_o
    );

    modport slave (
        input  cmd_vld_i, cmd_op_i, cmd_arg_i, smpls_i, stb_i, trg_i, rd_done_i,
        output fdiv_o, set_div_o, we_o, wdata_o, rd_start_o, rd_len_o, state_o, err_o
    );
endinterface

// File: rtl/capture_ctrl.sv
// Capture run sequencer: arm, qualify trigger on strobes, count post-trigger samples, start readout.
// All outputs are registered; memory writes are gated to strobes belonging to the current capture.
module capture_ctrl #(
    parameter int unsigned CHLS  = 32,
    parameter int unsigned CNT_W = 16
) (
    input logic      clk_i,
    input logic      rst_i,
    capture_if.slave bus
);
    localparam logic [7:0] OpReset  = 8'h00;
    localparam logic [7:0] OpArm    = 8'h01;
    localparam logic [7:0] OpSetDiv = 8'h80;
    localparam logic [7:0] OpSetCnt = 8'h81;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StDelay = 2'd2,
        StRead  = 2'd3
    } state_e;

    state_e           state_q;
    logic [23:0]      fdiv_q;
    logic             set_div_q;
    logic             we_q;
    logic [CHLS-1:0]  wdata_q;
    logic             rd_start_q;
    logic [CNT_W-1:0] rd_len_q;
    logic             err_q;
    logic [CNT_W-1:0] delay_cnt_q;
    logic [CNT_W-1:0] read_cnt_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            fdiv_q      <= '0;
            set_div_q   <= 1'b0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            rd_start_q  <= 1'b0;
            rd_len_q    <= '0;
            err_q       <= 1'b0;
            delay_cnt_q <= '0;
            read_cnt_q  <= '0;
            cnt_q       <= '0;
        end else begin
            set_div_q  <= 1'b0;
            rd_start_q <= 1'b0;
            we_q       <= 1'b0;

            if (bus.stb_i && (state_q == StArmed || state_q == StDelay)) begin
                we_q    <= 1'b1;
                wdata_q <= bus.smpls_i;
            end

            unique case (state_q)
                StIdle: ;
                StArmed: begin
                    if (bus.stb_i && bus.trg_i) begin
                        if (delay_cnt_q == '0) begin
                            state_q    <= StRead;
                            rd_start_q <= 1'b1;
                            rd_len_q   <= read_cnt_q;
                        end else begin
                            cnt_q   <= delay_cnt_q;
                            state_q <= StDelay;
                        end
                    end
                end
                StDelay: begin
                    if (bus.stb_i && cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == CNT_W'(1)) begin
                            state_q    <= StRead;
                            rd_start_q <= 1'b1;
                            rd_len_q   <= read_cnt_q;
                        end
                    end
                end
                StRead: begin
                    if (bus.rd_done_i) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase

            // Commands are handled last so RESET overrides any transition or pulse decided above.
            if (bus.cmd_vld_i) begin
                case (bus.cmd_op_i)
                    OpReset: begin
                        state_q    <= StIdle;
                        err_q      <= 1'b0;
                        we_q       <= 1'b0;
                        rd_start_q <= 1'b0;
                        set_div_q  <= 1'b0;
                    end
                    OpArm: begin
                        if (state_q == StIdle) state_q <= StArmed;
                        else                   err_q   <= 1'b1;
                    end
                    OpSetDiv: begin
                        if (state_q == StIdle) begin
                            fdiv_q    <= bus.cmd_arg_i[23:0];
                            set_div_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    OpSetCnt: begin
                        if (state_q == StIdle) begin
                            read_cnt_q  <= bus.cmd_arg_i[CNT_W-1:0];
                            delay_cnt_q <= bus.cmd_arg_i[16+CNT_W-1:16];
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.fdiv_o     = fdiv_q;
    assign bus.set_div_o  = set_div_q;
    assign bus.we_o       = we_q;
    assign bus.wdata_o    = wdata_q;
    assign bus.rd_start_o = rd_start_q;
    assign bus.rd_len_o   = rd_len_q;
    assign bus.state_o    = state_q;
    assign bus.err_o      = err_q;
endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl: command handling, trigger/delay sequencing, readout handoff,
// error flag and asynchronous reset.
module tb_capture_ctrl;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;
    int   we_cnt;

    capture_if #(.CHLS(32), .CNT_W(16)) bus ();

    capture_ctrl #(.CHLS(32), .CNT_W(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (bus.we_o === 1'b1) we_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [7:0] op, input logic [31:0] arg);
        bus.cmd_vld_i = 1'b1;
        bus.cmd_op_i  = op;
        bus.cmd_arg_i = arg;
        tick();
        bus.cmd_vld_i = 1'b0;
    endtask

    // One strobe cycle; outputs are observed right after the edge that consumed it.
    task automatic strobe(input logic [31:0] data, input logic trg);
        bus.stb_i   = 1'b1;
        bus.trg_i   = trg;
        bus.smpls_i = data;
        tick();
        bus.stb_i = 1'b0;
        bus.trg_i = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        we_cnt = 0;
        bus.cmd_vld_i = 1'b0;
        bus.cmd_op_i  = 8'h00;
        bus.cmd_arg_i = 32'h0;
        bus.smpls_i   = 32'h0;
        bus.stb_i     = 1'b0;
        bus.trg_i     = 1'b0;
        bus.rd_done_i = 1'b0;
        rst = 1'b1;
        tick();
        tick();

        chk("rst_state", 32'(bus.state_o), 32'd0);
        chk("rst_we", 32'(bus.we_o), 32'd0);
        chk("rst_fdiv", 32'(bus.fdiv_o), 32'd0);
        chk("rst_set_div", 32'(bus.set_div_o), 32'd0);
        chk("rst_rd_start", 32'(bus.rd_start_o), 32'd0);
        chk("rst_rd_len", 32'(bus.rd_len_o), 32'd0);
        chk("rst_err", 32'(bus.err_o), 32'd0);
        rst = 1'b0;
        tick();

        // SET_DIV single pulse
        cmd(8'h80, 32'h0000_1234);
        chk("setdiv_fdiv", 32'(bus.fdiv_o), 32'h1234);
        chk("setdiv_pulse", 32'(bus.set_div_o), 32'd1);
        tick();
        chk("setdiv_pulse_end", 32'(bus.set_div_o), 32'd0);
        chk("setdiv_hold", 32'(bus.fdiv_o), 32'h1234);

        // Back-to-back SET_DIV repeats the pulse with the new value
        cmd(8'h80, 32'h0000_0005);
        chk("setdiv_b2b_a", 32'(bus.fdiv_o), 32'h5);
        cmd(8'h80, 32'h0000_1234);
        chk("setdiv_b2b_pulse", 32'(bus.set_div_o), 32'd1);
        chk("setdiv_b2b_b", 32'(bus.fdiv_o), 32'h1234);
        tick();
        chk("setdiv_b2b_end", 32'(bus.set_div_o), 32'd0);

        // Main capture: delay 3, read 8; ARM cycle strobe is not written
        cmd(8'h81, 32'h0003_0008);
        we_cnt = 0;
        bus.stb_i = 1'b1;
        bus.smpls_i = 32'hDEAD_0000;
        cmd(8'h01, 32'h0);
        bus.stb_i = 1'b0;
        chk("arm_state", 32'(bus.state_o), 32'd1);
        chk("arm_strobe_no_we", 32'(bus.we_o), 32'd0);
        tick();

        bus.trg_i = 1'b1;
        tick();
        bus.trg_i = 1'b0;
        chk("trg_nostb_state", 32'(bus.state_o), 32'd1);
        chk("trg_nostb_we", 32'(bus.we_o), 32'd0);

        bus.rd_done_i = 1'b1;
        tick();
        bus.rd_done_i = 1'b0;
        chk("rd_done_armed_ignored", 32'(bus.state_o), 32'd1);

        for (int i = 1; i <= 5; i++) begin
            strobe(32'hA000_0000 + 32'(i), 1'b0);
            chk("pre_we", 32'(bus.we_o), 32'd1);
            tick();
        end
        chk("pre_wdata", bus.wdata_o, 32'hA000_0005);
        chk("pre_state", 32'(bus.state_o), 32'd1);

        strobe(32'hA000_0006, 1'b1);
        chk("trig_wdata", bus.wdata_o, 32'hA000_0006);
        chk("trig_state", 32'(bus.state_o), 32'd2);
        tick();

        strobe(32'hA000_0007, 1'b1);
        chk("delay1_state", 32'(bus.state_o), 32'd2);
        tick();
        strobe(32'hA000_0008, 1'b0);
        chk("delay2_state", 32'(bus.state_o), 32'd2);
        tick();
        strobe(32'hA000_0009, 1'b0);
        chk("delay3_state", 32'(bus.state_o), 32'd3);
        chk("delay3_wdata", bus.wdata_o, 32'hA000_0009);
        chk("rd_start", 32'(bus.rd_start_o), 32'd1);
        chk("rd_len", 32'(bus.rd_len_o), 32'd8);
        tick();
        chk("rd_start_end", 32'(bus.rd_start_o), 32'd0);

        strobe(32'hA000_000A, 1'b0);
        chk("read_no_we10", 32'(bus.we_o), 32'd0);
        strobe(32'hA000_000B, 1'b0);
        chk("read_no_we11", 32'(bus.we_o), 32'd0);
        tick();
        chk("we_total", 32'(we_cnt), 32'd9);
        chk("rd_len_hold", 32'(bus.rd_len_o), 32'd8);

        bus.rd_done_i = 1'b1;
        tick();
        bus.rd_done_i = 1'b0;
        chk("rd_done_idle", 32'(bus.state_o), 32'd0);

        // Zero delay: trigger sample written, READ next cycle
        cmd(8'h81, 32'h0000_0002);
        cmd(8'h01, 32'h0);
        we_cnt = 0;
        strobe(32'hB000_0001, 1'b1);
        chk("d0_state", 32'(bus.state_o), 32'd3);
        chk("d0_we", 32'(bus.we_o), 32'd1);
        chk("d0_rd_start", 32'(bus.rd_start_o), 32'd1);
        chk("d0_rd_len", 32'(bus.rd_len_o), 32'd2);
        tick();
        chk("d0_we_total", 32'(we_cnt), 32'd1);

        // RESET together with rd_done
        bus.rd_done_i = 1'b1;
        cmd(8'h00, 32'h0);
        bus.rd_done_i = 1'b0;
        chk("reset_rddone_state", 32'(bus.state_o), 32'd0);

        // RESET together with a trigger strobe in ARMED
        cmd(8'h01, 32'h0);
        bus.stb_i = 1'b1;
        bus.trg_i = 1'b1;
        cmd(8'h00, 32'h0);
        bus.stb_i = 1'b0;
        bus.trg_i = 1'b0;
        chk("reset_trg_state", 32'(bus.state_o), 32'd0);
        chk("reset_trg_we", 32'(bus.we_o), 32'd0);

        // Error flag: unknown opcode silent, ARM in DELAY and SET_DIV in READ flagged
        cmd(8'h81, 32'h0002_0004);
        cmd(8'h01, 32'h0);
        cmd(8'h55, 32'h0);
        chk("unknown_op_no_err", 32'(bus.err_o), 32'd0);
        strobe(32'hC000_0001, 1'b1);
        tick();
        cmd(8'h01, 32'h0);
        chk("arm_delay_err", 32'(bus.err_o), 32'd1);
        chk("arm_delay_state", 32'(bus.state_o), 32'd2);
        strobe(32'hC000_0002, 1'b0);
        tick();
        strobe(32'hC000_0003, 1'b0);
        chk("err_read_state", 32'(bus.state_o), 32'd3);
        cmd(8'h80, 32'h00AB_CDEF);
        chk("setdiv_read_fdiv", 32'(bus.fdiv_o), 32'h1234);
        chk("setdiv_read_pulse", 32'(bus.set_div_o), 32'd0);
        chk("err_sticky", 32'(bus.err_o), 32'd1);
        cmd(8'h00, 32'h0);
        chk("reset_err_clr", 32'(bus.err_o), 32'd0);
        chk("reset_state", 32'(bus.state_o), 32'd0);
        chk("reset_keeps_fdiv", 32'(bus.fdiv_o), 32'h1234);

        // Asynchronous reset mid-DELAY
        cmd(8'h81, 32'h0005_0001);
        cmd(8'h01, 32'h0);
        strobe(32'hD000_0001, 1'b1);
        tick();
        strobe(32'hD000_0002, 1'b0);
        chk("pre_async_we", 32'(bus.we_o), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_we", 32'(bus.we_o), 32'd0);
        chk("async_state", 32'(bus.state_o), 32'd0);
        chk("async_fdiv", 32'(bus.fdiv_o), 32'd0);
        chk("async_wdata", bus.wdata_o, 32'd0);
        tick();
        #2;
        rst = 1'b0;
        tick();
        chk("post_rst_state", 32'(bus.state_o), 32'd0);
        strobe(32'hE000_0001, 1'b0);
        chk("post_rst_no_we", 32'(bus.we_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
